mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Consumer end of the EX/MEM pipeline register. Takes the EX_MEM_* bundle and performs the
//  data-memory access over a req/ack handshake. Stalls upstream stages while an access is
//  outstanding, then registers the write-back bundle (MEM_WB_*) for the WB stage.
// PARAMETERS
//  DATA_W   8   datapath width (alu_out, B, shift_out, memory data/address)
//  INSTR_W  19  instruction field carried down the pipe
//  TIMEOUT  15  max WAIT cycles without ack (used only with MEM_WB_TIMEOUT_EN)
// PORTS
//  clk                 in   1        single clock, rising edge
//  reset               in   1        asynchronous, active-low; clears all state
//  EX_MEM_alu_out      in   DATA_W   ALU result; memory address
//  EX_MEM_B            in   DATA_W   store data
//  EX_MEM_shift_out    in   DATA_W   shifter result
//  EX_MEM_mem_write    in   1        store request
//  EX_MEM_reg_write    in   1        write-back enable
//  EX_MEM_instruction  in   INSTR_W  instruction (dest field used by WB)
//  EX_MEM_reg_write_mux in  2        WB source: 00 alu, 01 memory (load), 10 shift, 11 = alu
//  dmem_req            out  1        registered access request
//  dmem_we             out  1        registered write strobe (valid with dmem_req)
//  dmem_addr           out  DATA_W   registered address
//  dmem_wdata          out  DATA_W   registered store data
//  dmem_rdata          in   DATA_W   load data, sampled on ack
//  dmem_ack            in   1        access complete, one cycle
//  mem_stall           out  1        combinational; holds PC, IF/ID, ID/EX, EX/MEM
//  mem_err             out  1        sticky timeout flag (constant 0 without macro)
//  MEM_WB_alu_out, MEM_WB_mem_data, MEM_WB_shift_out  out DATA_W  registered WB data
//  MEM_WB_reg_write    out  1        registered write-back enable
//  MEM_WB_reg_write_mux out 2        registered WB source select
//  MEM_WB_instruction  out  INSTR_W  registered instruction
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; all outputs and MEM_WB_* = 0; counter = 0; mem_err = 0.
//  - mem_op = EX_MEM_mem_write | (EX_MEM_reg_write_mux==2'b01).
//  - FSM IDLE:
//    - !mem_op: stall=0; next edge MEM_WB_* <= EX_MEM_* with mem_data <= 0.
//    - mem_op: stall=1; next edge: latch dmem_addr=alu_out, dmem_wdata=B,
//      dmem_we=mem_write, set dmem_req=1; go WAIT; MEM_WB gets a bubble.
//  - FSM WAIT: dmem_req held and addr/data/we stable.
//    - !dmem_ack: stall=1, bubble into MEM_WB.
//    - dmem_ack: stall=0; next edge: dmem_req<=0; MEM_WB_* <= EX_MEM_*;
//      mem_data <= dmem_rdata if load, else 0; go IDLE.
//  - Bubble: MEM_WB_reg_write=0, mux=00, data/instruction fields = 0.
//  - Latency: non-mem op 1 cycle. Mem op 1 + N cycles for ack in WAIT cycle N (N>=1);
//    minimum 2 cycles, back-to-back mem ops 2 cycles each.
//  - dmem_ack in IDLE is ignored.
//  - Store with reg_write=1 passes reg_write through unchanged.
//  - Mux=11 is treated as alu and is not a memory op.
//  - Async reset mid-WAIT: dmem_req drops immediately and the access is abandoned.
//  - EX_MEM inputs are stable while stall=1 (upstream holds).
// CONFIGURATION
//  MEM_WB_TIMEOUT_EN defined:
//    - A WAIT-cycle counter starts at 0 on WAIT entry.
//    - If no ack by the TIMEOUT-th WAIT cycle: stall=0 that cycle; next edge dmem_req<=0,
//      bubble into MEM_WB (instruction dropped), mem_err<=1 (sticky until reset), go IDLE.
//    - An ack arriving in the TIMEOUT-th cycle wins: normal completion.
//  Undefined:
//    - No counter; WAIT is held indefinitely; mem_err tied 0.
// TESTING
//  1 ALU op: alu_out=8'h3C, mux=00, reg_write=1 -> next cycle MEM_WB_alu_out=3C, reg_write=1, stall=0.
//  2 Load: addr 8'h10, ack 3 cycles after req, rdata=8'hA5 -> stall=1 for 3 cycles;
//    MEM_WB_mem_data=A5, mux=01 on the edge after ack; bubbles before.
//  3 Store: alu_out=8'h20, B=8'h77, mem_write=1 -> dmem_req=1, we=1, addr=20, wdata=77 until ack;
//    spurious ack in IDLE ignored.
//  4 Back-to-back loads, each acked in the 1st WAIT cycle -> each completes in 2 cycles, data in order.
//  5 Reset low in 2nd WAIT cycle -> dmem_req and MEM_WB_* = 0 immediately; after release, IDLE, no req.
//  6 MEM_WB_TIMEOUT_EN, TIMEOUT=4, no ack -> after 4 WAIT cycles req drops, mem_err=1, bubble;
//    without macro, req and stall stay high.

Source files
------------

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : Consumer end of the EX/MEM pipeline register. Performs the
//               data-memory access over a req/ack handshake, stalls the
//               upstream stages while an access is outstanding and registers
//               the write-back bundle (MEM_WB_*) for the WB stage.
//               Optional feature macro: MEM_WB_TIMEOUT_EN (WAIT-state
//               watchdog that abandons an unacknowledged access and raises
//               the sticky mem_err flag).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 19,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,

  // EX/MEM bundle from the previous stage
  input  logic [DATA_W-1:0]  EX_MEM_alu_out,
  input  logic [DATA_W-1:0]  EX_MEM_B,
  input  logic [DATA_W-1:0]  EX_MEM_shift_out,
  input  logic               EX_MEM_mem_write,
  input  logic               EX_MEM_reg_write,
  input  logic [INSTR_W-1:0] EX_MEM_instruction,
  input  logic [1:0]         EX_MEM_reg_write_mux,

  // Data-memory handshake
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,

  // Pipeline control / status
  output logic               mem_stall,
  output logic               mem_err,

  // MEM/WB bundle towards the WB stage
  output logic [DATA_W-1:0]  MEM_WB_alu_out,
  output logic [DATA_W-1:0]  MEM_WB_mem_data,
  output logic [DATA_W-1:0]  MEM_WB_shift_out,
  output logic               MEM_WB_reg_write,
  output logic [1:0]         MEM_WB_reg_write_mux,
  output logic [INSTR_W-1:0] MEM_WB_instruction
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WAIT  = 1'b1;

  // Write-back source encoding: 01 selects memory data (i.e. a load)
  localparam logic [1:0] MUX_MEM = 2'b01;

  // --------------------------------------------------------------------------
  // State and next-state
  // --------------------------------------------------------------------------
  logic [0:0]         state_q, state_d;

  // Memory-port registers: held stable for the whole WAIT phase
  logic               req_q,   req_d;
  logic               we_q,    we_d;
  logic [DATA_W-1:0]  addr_q,  addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  // Write-back bundle registers
  logic [DATA_W-1:0]  wb_alu_q,   wb_alu_d;
  logic [DATA_W-1:0]  wb_mdata_q, wb_mdata_d;
  logic [DATA_W-1:0]  wb_shift_q, wb_shift_d;
  logic               wb_rw_q,    wb_rw_d;
  logic [1:0]         wb_mux_q,   wb_mux_d;
  logic [INSTR_W-1:0] wb_instr_q, wb_instr_d;

  // Combinational helpers
  logic               w_mem_op;    // current EX/MEM instruction touches memory
  logic               w_is_load;   // current EX/MEM instruction is a load
  logic               w_timeout;   // watchdog expires this WAIT cycle
  logic               w_wb_load;   // capture EX/MEM into MEM/WB (else bubble)
  logic               w_stall;

  // A store or a load needs the memory; mux 11 is an ALU alias, not a load
  assign w_is_load = (EX_MEM_reg_write_mux == MUX_MEM);
  assign w_mem_op  = EX_MEM_mem_write | w_is_load;

  // --------------------------------------------------------------------------
  // Optional WAIT-state watchdog
  // --------------------------------------------------------------------------
`ifdef MEM_WB_TIMEOUT_EN
  // Counter holds (WAIT cycle index - 1), so it only needs to reach TIMEOUT-1
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Expires on the TIMEOUT-th WAIT cycle; a same-cycle ack takes priority
  assign w_timeout = (state_q == S_WAIT) && !dmem_ack &&
                     (cnt_q == CNT_W'(TIMEOUT - 1));

  // Count WAIT cycles; restart from zero on every WAIT entry
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (!dmem_ack && !w_timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Error flag is sticky until reset
  always_comb begin
    err_d = err_q | w_timeout;
  end

  // Watchdog state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  // Without the watchdog the parameter has no effect; WAIT is held forever
  localparam int unused_timeout = TIMEOUT;

  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Control FSM and memory-port next state
  // --------------------------------------------------------------------------
  // Sequence IDLE -> WAIT -> IDLE around each memory access
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    w_wb_load = 1'b0;
    w_stall   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // dmem_ack is deliberately ignored here
        if (w_mem_op) begin
          w_stall = 1'b1;
          state_d = S_WAIT;
          req_d   = 1'b1;
          we_d    = EX_MEM_mem_write;
          addr_d  = EX_MEM_alu_out;
          wdata_d = EX_MEM_B;
        end else begin
          w_wb_load = 1'b1;
        end
      end

      S_WAIT: begin
        if (dmem_ack) begin
          // Access complete: release upstream and retire the instruction
          state_d   = S_IDLE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          w_wb_load = 1'b1;
        end else if (w_timeout) begin
          // Abandon the access; the instruction is dropped as a bubble
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end else begin
          w_stall = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Write-back bundle next state
  // --------------------------------------------------------------------------
  // Pass EX/MEM through when retiring, otherwise insert an all-zero bubble.
  // A load can only retire from WAIT, so rdata is always the acked data here.
  always_comb begin
    wb_alu_d   = '0;
    wb_mdata_d = '0;
    wb_shift_d = '0;
    wb_rw_d    = 1'b0;
    wb_mux_d   = 2'b00;
    wb_instr_d = '0;
    if (w_wb_load) begin
      wb_alu_d   = EX_MEM_alu_out;
      wb_mdata_d = w_is_load ? dmem_rdata : '0;
      wb_shift_d = EX_MEM_shift_out;
      wb_rw_d    = EX_MEM_reg_write;
      wb_mux_d   = EX_MEM_reg_write_mux;
      wb_instr_d = EX_MEM_instruction;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // FSM and memory-port registers; async reset drops dmem_req immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // MEM/WB pipeline register, updated every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_alu_q   <= '0;
      wb_mdata_q <= '0;
      wb_shift_q <= '0;
      wb_rw_q    <= 1'b0;
      wb_mux_q   <= 2'b00;
      wb_instr_q <= '0;
    end else begin
      wb_alu_q   <= wb_alu_d;
      wb_mdata_q <= wb_mdata_d;
      wb_shift_q <= wb_shift_d;
      wb_rw_q    <= wb_rw_d;
      wb_mux_q   <= wb_mux_d;
      wb_instr_q <= wb_instr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_stall            = w_stall;

  assign dmem_req             = req_q;
  assign dmem_we              = we_q;
  assign dmem_addr            = addr_q;
  assign dmem_wdata           = wdata_q;

  assign MEM_WB_alu_out       = wb_alu_q;
  assign MEM_WB_mem_data      = wb_mdata_q;
  assign MEM_WB_shift_out     = wb_shift_q;
  assign MEM_WB_reg_write     = wb_rw_q;
  assign MEM_WB_reg_write_mux = wb_mux_q;
  assign MEM_WB_instruction   = wb_instr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage. A driver issues
//               directed and random instructions and acts as the data
//               memory; expected retirements go into a scoreboard queue that
//               a separate monitor drains as MEM_WB presents results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  localparam int DW = 8;
  localparam int IW = 19;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] EX_MEM_alu_out = '0, EX_MEM_B = '0, EX_MEM_shift_out = '0;
  logic          EX_MEM_mem_write = 1'b0, EX_MEM_reg_write = 1'b0;
  logic [IW-1:0] EX_MEM_instruction = '0;
  logic [1:0]    EX_MEM_reg_write_mux = 2'b00;
  logic          dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_ack = 1'b0;
  logic          mem_stall, mem_err;
  logic [DW-1:0] MEM_WB_alu_out, MEM_WB_mem_data, MEM_WB_shift_out;
  logic          MEM_WB_reg_write;
  logic [1:0]    MEM_WB_reg_write_mux;
  logic [IW-1:0] MEM_WB_instruction;

  mem_wb_stage #(.DATA_W(DW), .INSTR_W(IW), .TIMEOUT(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .EX_MEM_alu_out      (EX_MEM_alu_out),
    .EX_MEM_B            (EX_MEM_B),
    .EX_MEM_shift_out    (EX_MEM_shift_out),
    .EX_MEM_mem_write    (EX_MEM_mem_write),
    .EX_MEM_reg_write    (EX_MEM_reg_write),
    .EX_MEM_instruction  (EX_MEM_instruction),
    .EX_MEM_reg_write_mux(EX_MEM_reg_write_mux),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_rdata          (dmem_rdata),
    .dmem_ack            (dmem_ack),
    .mem_stall           (mem_stall),
    .mem_err             (mem_err),
    .MEM_WB_alu_out      (MEM_WB_alu_out),
    .MEM_WB_mem_data     (MEM_WB_mem_data),
    .MEM_WB_shift_out    (MEM_WB_shift_out),
    .MEM_WB_reg_write    (MEM_WB_reg_write),
    .MEM_WB_reg_write_mux(MEM_WB_reg_write_mux),
    .MEM_WB_instruction  (MEM_WB_instruction)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected retirement: cycle (as seen at the following negedge) and bundle
  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] alu, md, sh;
    logic          rw;
    logic [1:0]    mux;
    logic [IW-1:0] ins;
  } rec_t;

  rec_t          sb_q[$];
  logic [DW-1:0] mem_m [256];   // data-memory contents as the bench sees them
  int            vectors = 0;
  int            miscompares = 0;
  logic          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every non-bubble MEM_WB output must match the oldest expectation
  initial begin
    rec_t r;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (MEM_WB_instruction != '0) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_retire: got instr %0h, required none", MEM_WB_instruction);
        end else begin
          r = sb_q.pop_front();
          chk("retire_cycle", cyc, r.cyc);
          chk("wb_instr", MEM_WB_instruction, r.ins);
          chk("wb_alu", MEM_WB_alu_out, r.alu);
          chk("wb_mem_data", MEM_WB_mem_data, r.md);
          chk("wb_shift", MEM_WB_shift_out, r.sh);
          chk("wb_reg_write", MEM_WB_reg_write, r.rw);
          chk("wb_mux", MEM_WB_reg_write_mux, r.mux);
        end
      end else begin
        chk("bubble", {MEM_WB_alu_out, MEM_WB_mem_data, MEM_WB_shift_out,
                       5'(MEM_WB_reg_write_mux), MEM_WB_reg_write}, 32'd0);
      end
    end
  end

  // Issue one instruction; for memory ops, ack arrives in WAIT cycle n.
  // Called and returns at posedge+1.
  task automatic run_instr(input logic [DW-1:0] alu, input logic [DW-1:0] b,
                           input logic [DW-1:0] sh, input logic mw, input logic rw,
                           input logic [1:0] mux, input logic [IW-1:0] ins,
                           input int n, input logic spur);
    logic mop, ld;
    rec_t r;
    ld  = (mux == 2'b01);
    mop = mw | ld;
    EX_MEM_alu_out       = alu;
    EX_MEM_B             = b;
    EX_MEM_shift_out     = sh;
    EX_MEM_mem_write     = mw;
    EX_MEM_reg_write     = rw;
    EX_MEM_reg_write_mux = mux;
    EX_MEM_instruction   = ins;
    dmem_ack             = spur;
    dmem_rdata           = 8'($urandom);
    r.cyc = cyc + 1 + (mop ? n : 0);
    r.alu = alu;
    r.md  = ld ? mem_m[alu] : '0;
    r.sh  = sh;
    r.rw  = rw;
    r.mux = mux;
    r.ins = ins;
    sb_q.push_back(r);
    @(negedge clk);
    chk("stall_issue", mem_stall, mop);
    @(posedge clk); #1;
    if (mop) begin
      for (int k = 1; k <= n; k++) begin
        dmem_ack   = (k == n);
        dmem_rdata = (k == n && ld) ? mem_m[alu] : 8'($urandom);
        @(negedge clk);
        chk("req_held", dmem_req, 1);
        chk("req_we", dmem_we, mw);
        chk("req_addr", dmem_addr, alu);
        chk("req_wdata", dmem_wdata, b);
        chk("stall_wait", mem_stall, (k != n));
        @(posedge clk); #1;
      end
      chk("req_drop", dmem_req, 0);
      if (mw) mem_m[alu] = b;
    end
    dmem_ack = 1'b0;
  endtask

  task automatic idle_inputs();
    EX_MEM_alu_out = '0; EX_MEM_B = '0; EX_MEM_shift_out = '0;
    EX_MEM_mem_write = 1'b0; EX_MEM_reg_write = 1'b0;
    EX_MEM_reg_write_mux = 2'b00; EX_MEM_instruction = '0;
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic [1:0]    mux;
    logic          mw;
    logic [DW-1:0] a;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'(i) ^ 8'h5A;
    mem_m[8'h10] = 8'hA5;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_wb", {MEM_WB_alu_out, MEM_WB_instruction}, 0);
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // 1: ALU op
    run_instr(8'h3C, 8'h00, 8'h11, 1'b0, 1'b1, 2'b00, 19'h00101, 1, 1'b0);
    // 2: load, ack in third WAIT cycle
    run_instr(8'h10, 8'h00, 8'h22, 1'b0, 1'b1, 2'b01, 19'h00202, 3, 1'b0);
    // 3: store with reg_write passthrough, then ALU op with spurious ack in IDLE
    run_instr(8'h20, 8'h77, 8'h33, 1'b1, 1'b1, 2'b00, 19'h00303, 2, 1'b0);
    run_instr(8'h55, 8'h66, 8'h44, 1'b0, 1'b1, 2'b11, 19'h00404, 1, 1'b1);
    // 4: back-to-back loads acked in first WAIT cycle (second reads the store)
    run_instr(8'h11, 8'h00, 8'h01, 1'b0, 1'b1, 2'b01, 19'h00505, 1, 1'b0);
    run_instr(8'h20, 8'h00, 8'h02, 1'b0, 1'b1, 2'b01, 19'h00606, 1, 1'b0);

    // 5: async reset in the second WAIT cycle abandons the access
    EX_MEM_alu_out = 8'h44; EX_MEM_reg_write_mux = 2'b01;
    EX_MEM_reg_write = 1'b1; EX_MEM_instruction = 19'h00707;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", dmem_req, 1);
    reset = 1'b0;
    #1;
    chk("midrst_req", dmem_req, 0);
    chk("midrst_wb", {MEM_WB_instruction, 5'(MEM_WB_reg_write)}, 0);
    idle_inputs();
    @(negedge clk);
    chk("midrst_stall", mem_stall, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("postrst_req", dmem_req, 0);
      chk("postrst_stall", mem_stall, 0);
    end
    @(posedge clk); #1;

    // 6: no ack for a long time
`ifdef MEM_WB_TIMEOUT_EN
    EX_MEM_alu_out = 8'h30; EX_MEM_reg_write_mux = 2'b01;
    EX_MEM_reg_write = 1'b1; EX_MEM_instruction = 19'h00808;
    @(negedge clk);
    chk("to_stall_issue", mem_stall, 1);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("to_req", dmem_req, 1);
      chk("to_stall", mem_stall, (k < 4));
      @(posedge clk); #1;
    end
    chk("to_req_drop", dmem_req, 0);
    chk("to_err", mem_err, 1);
    idle_inputs();
    @(posedge clk); #1;
`else
    run_instr(8'h30, 8'h00, 8'h09, 1'b0, 1'b1, 2'b01, 19'h00808, 30, 1'b0);
`endif

    // Random stream
    for (int i = 0; i < 40; i++) begin
      mux = 2'($urandom);
      mw  = (mux != 2'b01) && ($urandom_range(0, 2) == 0);
      a   = (mw || mux == 2'b01) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      run_instr(a, 8'($urandom), 8'($urandom), mw, 1'($urandom), mux,
                19'($urandom) | 19'd1, $urandom_range(1, 4),
                ($urandom_range(0, 3) == 0));
    end

    idle_inputs();
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 0);
`ifdef MEM_WB_TIMEOUT_EN
    chk("final_err", mem_err, 1);
`else
    chk("final_err", mem_err, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
